// File: rtl/riscv_pkg.sv
// Shared RISC-V memory-side types: access width, sequencer FSM states and
// the width-to-byte-count helper.
package riscv_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_width_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } mem_seq_state_t;

  function automatic logic [3:0] width_to_size(input mem_width_t w);
    logic [3:0] s;
    s = 4'd1;
    case (w)
      MEM_B:   s = 4'd1;
      MEM_H:   s = 4'd2;
      MEM_W:   s = 4'd4;
      MEM_D:   s = 4'd8;
      default: s = 4'd1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/clarvi_lane_align.sv
// Maps access bytes onto beat lanes: byte enables and shifted write data for
// the current beat, and merge of returned read lanes into the accumulator.
module clarvi_lane_align #(
  parameter int BEAT_BYTES = 1
) (
  input  logic [2:0]              beat_index,
  input  logic [2:0]              lane_offset,
  input  logic [3:0]              access_size,
  input  logic [63:0]             wdata,
  input  logic [8*BEAT_BYTES-1:0] rdata,
  input  logic [63:0]             acc_in,
  output logic [BEAT_BYTES-1:0]   byte_enable,
  output logic [8*BEAT_BYTES-1:0] wbeat,
  output logic [63:0]             acc_out
);

  int k;

  always_comb begin
    byte_enable = '0;
    wbeat       = '0;
    acc_out     = acc_in;
    k           = 0;
    for (int j = 0; j < BEAT_BYTES; j++) begin
      // k is the access byte that lands in lane j of this beat
      k = int'(beat_index) * BEAT_BYTES + j - int'(lane_offset);
      if (k >= 0 && k < int'(access_size)) begin
        byte_enable[j]   = 1'b1;
        wbeat[j*8 +: 8]  = wdata[k*8 +: 8];
        acc_out[k*8 +: 8] = rdata[j*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/clarvi_mem_sequencer.sv
// Splits a 64-bit load/store request into memory beats and returns one response.
// Define MEM_SEQ_MISALIGNED_EN to allow accesses not aligned to their size.
module clarvi_mem_sequencer
  import riscv_pkg::*;
#(
  parameter int DATA_ADDR_WIDTH = 14,
  parameter int BEAT_BYTES      = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic                       req_unsigned,
  input  mem_width_t                 req_width,
  input  logic [63:0]                req_address,
  input  logic [63:0]                req_wdata,
  output logic [DATA_ADDR_WIDTH-1:0] mem_address,
  output logic [BEAT_BYTES-1:0]      mem_byte_enable,
  output logic                       mem_read_enable,
  output logic                       mem_write_enable,
  output logic [8*BEAT_BYTES-1:0]    mem_write_data,
  input  logic                       mem_wait,
  input  logic                       mem_read_valid,
  input  logic [8*BEAT_BYTES-1:0]    mem_read_data,
  output logic                       rsp_valid,
  output logic [63:0]                rsp_data,
  output logic                       rsp_error
);

  localparam int OFF_W = $clog2(BEAT_BYTES);
  localparam int TOP   = DATA_ADDR_WIDTH + OFF_W;

  function automatic logic [63:0] extend_load(input logic [63:0] v, input mem_width_t w,
                                              input logic uns);
    logic [63:0] r;
    r = v;
    case (w)
      MEM_B:   r = {{56{~uns & v[7]}},  v[7:0]};
      MEM_H:   r = {{48{~uns & v[15]}}, v[15:0]};
      MEM_W:   r = {{32{~uns & v[31]}}, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  mem_seq_state_t             state_q, state_d;
  logic [2:0]                 beat_q, beat_d;
  logic                       err_q;
  logic [DATA_ADDR_WIDTH-1:0] base_q;
  logic [2:0]                 off_q;
  logic [3:0]                 size_q;
  logic [3:0]                 nbeats_q;
  logic                       write_q, unsigned_q;
  mem_width_t                 width_q;
  logic [63:0]                wdata_q, acc_q, acc_merged;
  logic [BEAT_BYTES-1:0]      be_lane;
  logic [8*BEAT_BYTES-1:0]    wbeat;

  logic [3:0]                 req_size, req_beats;
  logic [2:0]                 req_off;
  logic [DATA_ADDR_WIDTH-1:0] req_base;
  logic                       req_fault, req_misal, latch, acc_load, last_beat, issuing;

  // Request decode: beat base, lane offset, beat count and fault checks
  always_comb begin
    req_size  = width_to_size(req_width);
    req_off   = req_address[2:0] & 3'(BEAT_BYTES - 1);
    req_base  = req_address[TOP-1:OFF_W];
    req_beats = 4'((5'(req_off) + 5'(req_size) + 5'(BEAT_BYTES - 1)) >> OFF_W);
    req_fault = |(req_address >> TOP);
`ifdef MEM_SEQ_MISALIGNED_EN
    req_misal = 1'b0;
`else
    req_misal = |(req_address[2:0] & (req_size[2:0] - 3'd1));
`endif
  end

  assign last_beat = ({1'b0, beat_q} + 4'd1) == nbeats_q;

  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    req_ready        = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    rsp_valid        = 1'b0;
    latch            = 1'b0;
    acc_load         = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          latch   = 1'b1;
          beat_d  = 3'd0;
          state_d = (req_fault || req_misal) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mem_write_enable = write_q;
        mem_read_enable  = ~write_q;
        if (!mem_wait) begin
          if (!write_q)       state_d = WAIT_RD;
          else if (last_beat) state_d = RESP;
          else                beat_d  = beat_q + 3'd1;
        end
      end
      WAIT_RD: begin
        if (mem_read_valid) begin
          acc_load = 1'b1;
          if (last_beat) begin
            state_d = RESP;
          end else begin
            beat_d  = beat_q + 3'd1;
            state_d = ISSUE;
          end
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      beat_q  <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (latch) err_q <= req_fault | req_misal;
    end
  end

  // Request fields and the read accumulator carry no reset; outputs are gated by state
  always_ff @(posedge clock) begin
    if (latch) begin
      base_q     <= req_base;
      off_q      <= req_off;
      size_q     <= req_size;
      nbeats_q   <= req_beats;
      write_q    <= req_write;
      unsigned_q <= req_unsigned;
      width_q    <= req_width;
      wdata_q    <= req_wdata;
      acc_q      <= '0;
    end else if (acc_load) begin
      acc_q <= acc_merged;
    end
  end

  clarvi_lane_align #(
    .BEAT_BYTES(BEAT_BYTES)
  ) u_lane_align (
    .beat_index (beat_q),
    .lane_offset(off_q),
    .access_size(size_q),
    .wdata      (wdata_q),
    .rdata      (mem_read_data),
    .acc_in     (acc_q),
    .byte_enable(be_lane),
    .wbeat      (wbeat),
    .acc_out    (acc_merged)
  );

  assign issuing         = (state_q == ISSUE);
  assign mem_address     = issuing ? base_q + DATA_ADDR_WIDTH'(beat_q) : '0;
  assign mem_byte_enable = issuing ? be_lane : '0;
  assign mem_write_data  = (issuing && write_q) ? wbeat : '0;
  assign rsp_error       = (state_q == RESP) && err_q;
  assign rsp_data        = ((state_q == RESP) && !err_q && !write_q)
                           ? extend_load(acc_q, width_q, unsigned_q) : 64'd0;

endmodule

// File: tb/tb_clarvi_mem_sequencer.sv
// Randomized bench for clarvi_mem_sequencer with a byte-level reference model
// and a 1-cycle beat memory that can stall and inject stray read_valid pulses.
module tb_clarvi_mem_sequencer;
  import riscv_pkg::*;

  localparam int DAW    = 14;
  localparam int BB     = 4;
  localparam int OFFW   = 2;
  localparam int NBYTES = 1 << (DAW + OFFW);

  typedef struct packed {
    logic [DAW-1:0] addr;
    logic [BB-1:0]  be;
    logic           wr;
  } beat_t;

  logic             clock, reset_n;
  logic             req_valid, req_ready, req_write, req_unsigned;
  mem_width_t       req_width;
  logic [63:0]      req_address, req_wdata;
  logic [DAW-1:0]   mem_address;
  logic [BB-1:0]    mem_byte_enable;
  logic             mem_read_enable, mem_write_enable;
  logic [8*BB-1:0]  mem_write_data, mem_read_data;
  logic             mem_wait, mem_read_valid;
  logic             rsp_valid, rsp_error;
  logic [63:0]      rsp_data;

  clarvi_mem_sequencer #(
    .DATA_ADDR_WIDTH(DAW),
    .BEAT_BYTES     (BB)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_unsigned    (req_unsigned),
    .req_width       (req_width),
    .req_address     (req_address),
    .req_wdata       (req_wdata),
    .mem_address     (mem_address),
    .mem_byte_enable (mem_byte_enable),
    .mem_read_enable (mem_read_enable),
    .mem_write_enable(mem_write_enable),
    .mem_write_data  (mem_write_data),
    .mem_wait        (mem_wait),
    .mem_read_valid  (mem_read_valid),
    .mem_read_data   (mem_read_data),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .rsp_error       (rsp_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, act, exp, $time);
    end
  endtask

  logic [8*BB-1:0] mem     [0:(1<<DAW)-1];
  logic [7:0]      ref_mem [0:NBYTES-1];
  beat_t           exp_q[$];

  int              wait_mode   = 0;   // 0 none, 1 random, 2 scripted on second beat
  int              script_left = 0;
  int              beats_done  = 0;
  logic            spurious_en = 1'b0;
  logic            hung        = 1'b0;

  logic            pend_rd, prev_hold, w;
  logic [DAW-1:0]  pend_addr;
  logic [63:0]     snap;
  beat_t           e;

  // Behavioural beat memory: decides stalls at the negedge before the edge it affects
  always @(negedge clock) begin
    if (!reset_n) begin
      pend_rd = 1'b0;
      prev_hold = 1'b0;
      mem_read_valid = 1'b0;
      mem_wait = 1'b0;
    end else begin
      if (prev_hold)
        check_eq("wait_hold", 64'({mem_address, mem_byte_enable, mem_read_enable,
                                   mem_write_enable, mem_write_data}), snap);
      if (pend_rd) begin
        mem_read_valid = 1'b1;
        mem_read_data  = mem[pend_addr];
        pend_rd        = 1'b0;
      end else if (spurious_en && $urandom_range(0, 3) == 0) begin
        mem_read_valid = 1'b1;
        mem_read_data  = $urandom;
      end else begin
        mem_read_valid = 1'b0;
      end
      w = 1'b0;
      if (mem_read_enable || mem_write_enable) begin
        if (wait_mode == 1) w = ($urandom_range(0, 2) == 0);
        else if (wait_mode == 2 && beats_done == 1 && script_left > 0) begin
          w = 1'b1;
          script_left--;
        end
      end
      mem_wait  = w;
      prev_hold = w && (mem_read_enable || mem_write_enable);
      snap = 64'({mem_address, mem_byte_enable, mem_read_enable, mem_write_enable, mem_write_data});
      if ((mem_read_enable || mem_write_enable) && !w) begin
        if (exp_q.size() == 0) begin
          check_eq("unexp_en", 64'({mem_read_enable, mem_write_enable}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("beat_addr", 64'(mem_address), 64'(e.addr));
          check_eq("beat_be", 64'(mem_byte_enable), 64'(e.be));
          check_eq("beat_dir", 64'({mem_read_enable, mem_write_enable}), 64'({~e.wr, e.wr}));
        end
        beats_done++;
        if (mem_write_enable) begin
          for (int l = 0; l < BB; l++)
            if (mem_byte_enable[l]) mem[mem_address][8*l +: 8] = mem_write_data[8*l +: 8];
        end else begin
          pend_rd   = 1'b1;
          pend_addr = mem_address;
        end
      end
    end
  end

  function automatic logic [63:0] ext(input logic [63:0] v, input int size, input logic uns);
    logic [63:0] m;
    m = (size == 8) ? '1 : ((64'd1 << (8 * size)) - 64'd1);
    if (uns || !v[8*size-1]) return v & m;
    return v | ~m;
  endfunction

  // Reference: walk the access byte by byte, group bytes into beats, update the byte image
  task automatic plan_req(input logic wr, input logic uns, input mem_width_t wd_t,
                          input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] ed, output logic ee, output int el);
    int size, ba, nb, lane;
    logic fault, mis;
    logic [63:0] v;
    beat_t cur;
    size  = 1 << int'(wd_t);
    fault = (a >> (DAW + OFFW)) != 64'd0;
`ifdef MEM_SEQ_MISALIGNED_EN
    mis = 1'b0;
`else
    mis = (a & 64'(size - 1)) != 64'd0;
`endif
    ee = fault | mis;
    ed = 64'd0;
    el = 1;
    v  = 64'd0;
    nb = 0;
    cur = '0;
    if (!ee) begin
      for (int k = 0; k < size; k++) begin
        ba   = int'((a + 64'(k)) & 64'(NBYTES - 1));
        lane = ba % BB;
        if (nb == 0 || cur.addr != DAW'(ba / BB)) begin
          if (nb > 0) exp_q.push_back(cur);
          cur.addr = DAW'(ba / BB);
          cur.be   = '0;
          cur.wr   = wr;
          nb++;
        end
        cur.be[lane] = 1'b1;
        if (wr) ref_mem[ba] = wd[8*k +: 8];
        else    v[8*k +: 8] = ref_mem[ba];
      end
      exp_q.push_back(cur);
      el = wr ? nb + 1 : 2 * nb + 1;
      if (!wr) ed = ext(v, size, uns);
    end
  endtask

  task automatic do_req(input logic wr, input logic uns, input mem_width_t wd_t,
                        input logic [63:0] a, input logic [63:0] wd, output logic [63:0] got);
    logic [63:0] ed;
    logic ee;
    int el, lat;
    plan_req(wr, uns, wd_t, a, wd, ed, ee, el);
    beats_done = 0;
    @(negedge clock);
    req_write = wr; req_unsigned = uns; req_width = wd_t;
    req_address = a; req_wdata = wd; req_valid = 1'b1;
    check_eq("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    while (rsp_valid !== 1'b1 && lat < 300) begin
      req_address = {$urandom, $urandom};
      req_wdata   = {$urandom, $urandom};
      req_write   = 1'($urandom_range(0, 1));
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    req_valid = 1'b0;
    got = rsp_data;
    if (rsp_valid !== 1'b1) begin
      check_eq("rsp_timeout", 64'(rsp_valid), 64'd1);
      hung = 1'b1;
      exp_q.delete();
    end else begin
      check_eq("rsp_error", 64'(rsp_error), 64'(ee));
      check_eq("rsp_data", rsp_data, ed);
      check_eq("beats_left", 64'(exp_q.size()), 64'd0);
      if (wait_mode == 0) check_eq("latency", 64'(lat), 64'(el));
      if (wait_mode == 2) check_eq("latency_wait", 64'(lat), 64'(el + 3));
      @(negedge clock);
      check_eq("rsp_one_cycle", 64'(rsp_valid), 64'd0);
      check_eq("ready_after", 64'(req_ready), 64'd1);
    end
  endtask

  task automatic poke(input int a, input logic [7:0] v);
    ref_mem[a] = v;
    mem[a / BB][8*(a % BB) +: 8] = v;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_en"}, 64'({mem_read_enable, mem_write_enable}), 64'd0);
    check_eq({tag, "_be"}, 64'(mem_byte_enable), 64'd0);
    check_eq({tag, "_ready"}, 64'(req_ready), 64'd1);
    check_eq({tag, "_rsp"}, 64'({rsp_valid, rsp_error}), 64'd0);
    check_eq({tag, "_data"}, rsp_data, 64'd0);
  endtask

  logic [63:0] got, ed, a, wd;
  logic        ee, wr, uns;
  int          el, bad;
  mem_width_t  wt;

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_unsigned = 1'b0; req_width = MEM_B;
    req_address = 64'd0; req_wdata = 64'd0;
    mem_wait = 1'b0; mem_read_valid = 1'b0; mem_read_data = '0;
    for (int i = 0; i < NBYTES; i++) poke(i, 8'($urandom));

    repeat (2) @(negedge clock);
    check_quiet("reset");
    reset_n = 1'b1;

    // Signed byte load from lane 3
    poke(3, 8'h80);
    do_req(1'b0, 1'b0, MEM_B, 64'h3, 64'd0, got);
    check_eq("sb_lane3", got, 64'hFFFF_FFFF_FFFF_FF80);
    do_req(1'b0, 1'b1, MEM_B, 64'h3, 64'd0, got);
    check_eq("ub_lane3", got, 64'h0000_0000_0000_0080);

    // Doubleword load spanning two beats
    for (int i = 0; i < 8; i++) poke(16 + i, 8'(i + 1));
    do_req(1'b0, 1'b0, MEM_D, 64'h10, 64'd0, got);
    check_eq("ld_d_0x10", got, 64'h0807_0605_0403_0201);

    // Word store at 0x6 (split when misaligned support is built in, error otherwise)
    do_req(1'b1, 1'b0, MEM_W, 64'h6, 64'hAABB_CCDD, got);
    do_req(1'b0, 1'b1, MEM_W, 64'h4, 64'd0, got);
    do_req(1'b0, 1'b1, MEM_W, 64'h8, 64'd0, got);

    // Address bit 40 set: access fault
    do_req(1'b0, 1'b0, MEM_W, (64'd1 << 40) | 64'h8, 64'd0, got);
    check_eq("fault_data", got, 64'd0);
    do_req(1'b1, 1'b0, MEM_D, 64'h1_0000, 64'h1234, got);

    // Three stall cycles on the second beat of a doubleword store
    wait_mode = 2; script_left = 3;
    do_req(1'b1, 1'b0, MEM_D, 64'h40, 64'h0123_4567_89AB_CDEF, got);
    wait_mode = 0;
    do_req(1'b0, 1'b0, MEM_D, 64'h40, 64'd0, got);
    check_eq("sd_readback", got, 64'h0123_4567_89AB_CDEF);

    // Reset while waiting for read data
    plan_req(1'b0, 1'b0, MEM_W, 64'h20, 64'd0, ed, ee, el);
    beats_done = 0;
    @(negedge clock);
    req_write = 1'b0; req_unsigned = 1'b0; req_width = MEM_W;
    req_address = 64'h20; req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1 check_quiet("midreset");
    check_eq("midreset_addr", 64'(mem_address), 64'd0);
    exp_q.delete();
    repeat (2) begin
      @(negedge clock);
      check_eq("midreset_norsp", 64'(rsp_valid), 64'd0);
    end
    reset_n = 1'b1;
    do_req(1'b0, 1'b0, MEM_W, 64'h20, 64'd0, got);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      if (hung) break;
      wait_mode   = $urandom_range(0, 1);
      spurious_en = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wt  = mem_width_t'($urandom_range(0, 3));
      case ($urandom_range(0, 15))
        0:       a = 64'($urandom_range(0, 255)) | (64'd1 << $urandom_range(16, 63));
        1:       a = 64'(NBYTES - 16 + $urandom_range(0, 15));
        default: a = 64'($urandom_range(0, 127));
      endcase
      if ($urandom_range(0, 1) == 1) a = a & ~64'((1 << int'(wt)) - 1);
      wd = {$urandom, $urandom};
      do_req(wr, uns, wt, a, wd, got);
    end
    wait_mode = 0;
    spurious_en = 1'b0;

    bad = 0;
    for (int i = 0; i < NBYTES; i++)
      if (mem[i / BB][8*(i % BB) +: 8] !== ref_mem[i]) bad++;
    check_eq("mem_image", 64'(bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
